shift_ctrl: RTL

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_if.sv | 31 +++
 rtl/shift_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/shift_ctrl_if.sv
// Bus between the keypad/auto sources and the shift-chain controller.
// Handshake: AUTO_REQ is a level held by the source until it sees AUTO_ACK=1
// for one cycle (that same cycle carries Ce=1 with Din=AUTO_DIN); the source
// must drop or renew AUTO_REQ in the following cycle. KEY_VALID is a level
// and a press is its rising edge. Ce/Din and SR_RST go to the 8x4-bit shift chain.
interface shift_ctrl_if;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       AUTO_REQ;
  logic [3:0] AUTO_DIN;
  logic       CLR;
  logic       Ce;
  logic [3:0] Din;
  logic       SR_RST;
  logic       AUTO_ACK;
  logic [3:0] COUNT;
  logic       FULL;
  logic       BUSY;

  // Source side: keypad, automatic source and clear request.
  modport master (
    output KEY_VALID, KEY_CODE, AUTO_REQ, AUTO_DIN, CLR,
    input  Ce, Din, SR_RST, AUTO_ACK, COUNT, FULL, BUSY
  );

  // Controller side.
  modport slave (
    input  KEY_VALID, KEY_CODE, AUTO_REQ, AUTO_DIN, CLR,
    output Ce, Din, SR_RST, AUTO_ACK, COUNT, FULL, BUSY
  );
endinterface

// File: rtl/shift_ctrl.sv
// Shift-chain controller: accepts digits from a keypad (edge-detected) or an
// automatic request/ack source and issues one-cycle Ce pulses to a 4-bit wide
// shift chain, tracking how many digits are held. Every output is a register;
// the combinational block computes next values which are then registered.
module shift_ctrl #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  shift_ctrl_if.slave bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    WAIT_REL = 2'd2,
    CLEAR    = 2'd3
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t     state, next_state;
  logic       key_prev;
  logic       from_key, from_key_n;
  logic       press;
  logic       ce_n, ack_n;
  logic [3:0] din_n, count_n;

  assign press     = bus.KEY_VALID & ~key_prev;
  assign dbg_state = state;

  // Next-state and next-output computation; CLR overrides everything.
  always_comb begin
    next_state = state;
    ce_n       = 1'b0;
    ack_n      = 1'b0;
    din_n      = bus.Din;
    count_n    = bus.COUNT;
    from_key_n = from_key;
    if (bus.CLR) begin
      next_state = CLEAR;
      count_n    = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (press) begin
            if (!bus.FULL) begin
              next_state = SHIFT;
              din_n      = bus.KEY_CODE;
              ce_n       = 1'b1;
              count_n    = bus.COUNT + 4'd1;
              from_key_n = 1'b1;
            end else begin
              // Chain full: swallow the press but still wait for release.
              next_state = WAIT_REL;
            end
          end else if (bus.AUTO_REQ && !bus.FULL) begin
            next_state = SHIFT;
            din_n      = bus.AUTO_DIN;
            ce_n       = 1'b1;
            ack_n      = 1'b1;
            count_n    = bus.COUNT + 4'd1;
            from_key_n = 1'b0;
          end
        end
        SHIFT: begin
          next_state = from_key ? WAIT_REL : IDLE;
        end
        WAIT_REL: begin
          if (!bus.KEY_VALID) next_state = IDLE;
        end
        CLEAR: begin
          count_n    = 4'd0;
          next_state = bus.KEY_VALID ? WAIT_REL : IDLE;
        end
        default: begin
          next_state = IDLE;
        end
      endcase
    end
  end

  // State and output registers; key_prev resets high so a key held through
  // reset is not mistaken for a fresh press.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state        <= IDLE;
      key_prev     <= 1'b1;
      from_key     <= 1'b0;
      bus.Ce       <= 1'b0;
      bus.Din      <= 4'd0;
      bus.SR_RST   <= 1'b0;
      bus.AUTO_ACK <= 1'b0;
      bus.COUNT    <= 4'd0;
      bus.FULL     <= 1'b0;
      bus.BUSY     <= 1'b0;
    end else begin
      state        <= next_state;
      key_prev     <= bus.KEY_VALID;
      from_key     <= from_key_n;
      bus.Ce       <= ce_n;
      bus.Din      <= din_n;
      bus.SR_RST   <= (next_state != CLEAR);
      bus.AUTO_ACK <= ack_n;
      bus.COUNT    <= count_n;
      bus.FULL     <= (count_n == MAX_CNT);
      bus.BUSY     <= (next_state != IDLE);
    end
  end

endmodule
